fsk_demod: RTL and testbench
============================

Name: fsk_demod

Overview:
- Non-coherent FSK receiver; recovers 12-bit words from the FSK modulator's single-bit output.
- Runs on the same `clk` as the modulator.
- Modulator symbol format:
  - one bit per SAMPLES clocks, LSB first, words sent back-to-back;
  - bit 1 = output toggles every clock;
  - bit 0 = output toggles every second clock.
- Demodulator counts transitions per symbol window and slices against thresholds. An external `align` pulse sets frame phase.

Parameters:
- BITS, 12, bits per word (width of `data_out`).
- SAMPLES, 16, clocks per symbol window.
- HI_MIN, 12, minimum edge count decoded as 1.
- LO_MAX, 10, maximum edge count decoded as 0. Counts strictly between LO_MAX and HI_MIN are ambiguous.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fsk_in  in  1  FSK line from the modulator (already synchronous to `clk`).
- align  in  1  frame-phase restart: the next clock starts window 0 (bit 0).
- data_out  out  BITS  last complete word, LSB = first received bit.
- data_valid  out  1  one-cycle pulse when `data_out` updates.
- bit_err  out  1  one-cycle pulse at the end of any window with an ambiguous count.
- locked  out  1  high while in RUN.

Behaviour:
- Reset (sync, active-high): all state and outputs cleared.
  - data_out=0, data_valid=0, bit_err=0, locked=0, prev=0, sample_cnt=0, edge_cnt=0, bit_idx=0, shift=0, state=IDLE.
  - Reset overrides `align` in the same cycle.
- prev <= fsk_in every non-reset cycle, in every state.
- edge = (fsk_in != prev).
- States:
  - IDLE: no counting. align=1 -> RUN with sample_cnt=0, edge_cnt=0, bit_idx=0, shift=0.
  - RUN: locked=1. align=1 forces the same restart; a partial word is discarded and data_valid is not pulsed. Holding `align` high keeps restarting, so window 0 begins on the clock after `align` falls.
- In RUN with align=0, each clock:
  - sample_cnt increments and edge_cnt adds `edge`.
  - Width: edge_cnt is clog2(SAMPLES+1) bits and never overflows (at most SAMPLES).
- Window end (sample_cnt==SAMPLES-1): decide on total = edge_cnt + edge (this cycle's edge included).
  - total >= HI_MIN -> bit 1.
  - total <= LO_MAX -> bit 0.
  - Otherwise bit 0 and bit_err pulses on the next cycle.
  - Bit written to shift[bit_idx].
  - Then sample_cnt=0, edge_cnt=0, bit_idx increments.
- Word end (bit_idx==BITS-1 at a window end):
  - data_out <= completed word (including the bit just decided); data_valid=1 for exactly one cycle.
  - bit_idx wraps to 0 and reception continues seamlessly into the next word.
  - If that bit is ambiguous, bit_err and data_valid pulse in the same cycle.
- Latency: with `align` high at edge t, the first data_valid is high after edge t+BITS*SAMPLES (t+192 at defaults). Subsequent words every 192 clocks.
- `data_out` holds its value between pulses. It is never partially updated.
- fsk_in stuck at constant level -> 0 edges -> word of all zeros, no bit_err.

Decomposition:
- Shared package `fsk_pkg`:
  - FSK_BITS=12, FSK_SAMPLES=16, default thresholds;
  - state enum {IDLE, RUN};
  - function computing count width. The modulator parameters are re-pointed to the same package constants.
- One natural sub-module `fsk_edge_counter`: prev register, edge detect, sample/edge counters, slicer outputs bit and err at the window end.
- Top level holds the FSM, bit index, shift register and output registers.

Test Plan:
- Ideal stimulus, word 12'hA5C:
  - Drive fsk_in from a behavioural modulator model: 16 toggles for a 1 bit, 8 toggles for a 0 bit.
  - Pulse align one cycle before the first symbol.
  - Expect: data_valid after 192 clocks, data_out=12'hA5C, bit_err never high, locked=1.
- Continuous stream of 12'hFFF, 12'h000, 12'h5A3:
  - Expect three data_valid pulses spaced exactly 192 clocks apart, in that order.
- Window containing exactly 11 edges:
  - Expect bit_err pulse one cycle after that window end and the corresponding data_out bit = 0.
  - Repeat with 12 edges -> bit 1, and 10 edges -> bit 0, both with no bit_err.
- Reset mid-frame:
  - Assert reset after 100 clocks of RUN.
  - Expect next cycle: all outputs 0, locked=0; no data_valid until align is given again.
- Re-align mid-word:
  - Pulse align 50 clocks into a word.
  - Expect no data_valid for the discarded word; next data_valid exactly 192 clocks after the align edge, with correct data.
- Idle behaviour:
  - Toggle fsk_in for 500 clocks without align.
  - Expect locked=0, data_valid=0, bit_err=0, data_out=0 throughout.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared constants, state encoding and width helper for the FSK link.
package fsk_pkg;

    localparam int FSK_BITS    = 12;
    localparam int FSK_SAMPLES = 16;
    localparam int FSK_HI_MIN  = 12;
    localparam int FSK_LO_MAX  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsk_state_e;

    // Width needed to hold an edge count of 0..samples inclusive.
    function automatic int fsk_cnt_width(input int samples);
        return $clog2(samples + 1);
    endfunction

endpackage

// File: rtl/fsk_edge_counter.sv
// Edge detector, per-window sample/edge counters and threshold slicer.
import fsk_pkg::*;

module fsk_edge_counter #(
    parameter int SAMPLES = FSK_SAMPLES,
    parameter int HI_MIN  = FSK_HI_MIN,
    parameter int LO_MAX  = FSK_LO_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic fsk_in,
    input  logic restart,
    input  logic count_en,
    output logic win_end,
    output logic bit_val,
    output logic bit_amb
);

    localparam int SW = $clog2(SAMPLES);
    localparam int CW = fsk_cnt_width(SAMPLES);
    localparam logic [SW-1:0] LAST_C = SW'(SAMPLES - 1);
    localparam logic [CW-1:0] HI_C   = CW'(HI_MIN);
    localparam logic [CW-1:0] LO_C   = CW'(LO_MAX);

    logic          prev_r;
    logic [SW-1:0] sample_cnt_r;
    logic [CW-1:0] edge_cnt_r;
    logic          edge_s;
    logic [CW-1:0] total_s;
    logic          win_end_s;

    // Edge detect and slicing of the window total (this cycle's edge included).
    always_comb begin
        edge_s  = (fsk_in != prev_r);
        total_s = edge_cnt_r + CW'(edge_s);
        if (count_en && (sample_cnt_r == LAST_C)) begin
            win_end_s = 1'b1;
        end else begin
            win_end_s = 1'b0;
        end
        bit_val = (total_s >= HI_C);
        bit_amb = (total_s > LO_C) && (total_s < HI_C);
    end

    assign win_end = win_end_s;

    // Previous-sample register and window counters; a restart zeroes the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r       <= 1'b0;
            sample_cnt_r <= '0;
            edge_cnt_r   <= '0;
        end else begin
            prev_r <= fsk_in;
            if (restart || win_end_s) begin
                sample_cnt_r <= '0;
                edge_cnt_r   <= '0;
            end else if (count_en) begin
                sample_cnt_r <= sample_cnt_r + SW'(1);
                edge_cnt_r   <= total_s;
            end else begin
                sample_cnt_r <= sample_cnt_r;
                edge_cnt_r   <= edge_cnt_r;
            end
        end
    end

endmodule

// File: rtl/fsk_demod.sv
// Non-coherent FSK demodulator: frame FSM, bit assembly and output registers.
import fsk_pkg::*;

module fsk_demod #(
    parameter int BITS    = FSK_BITS,
    parameter int SAMPLES = FSK_SAMPLES,
    parameter int HI_MIN  = FSK_HI_MIN,
    parameter int LO_MAX  = FSK_LO_MAX
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fsk_in,
    input  logic            align,
    output logic [BITS-1:0] data_out,
    output logic            data_valid,
    output logic            bit_err,
    output logic            locked
);

    localparam int IW = $clog2(BITS);
    localparam logic [IW-1:0] LAST_IDX_C = IW'(BITS - 1);

    fsk_state_e      state_r;
    logic [IW-1:0]   bit_idx_r;
    logic [BITS-1:0] shift_r;
    logic [BITS-1:0] data_out_r;
    logic            data_valid_r;
    logic            bit_err_r;
    logic            locked_r;
    logic            count_en_s;
    logic            win_end_s;
    logic            bit_val_s;
    logic            bit_amb_s;
    logic [BITS-1:0] word_s;

    // Counting only while running and not being re-aligned.
    always_comb begin
        if ((state_r == RUN) && !align) begin
            count_en_s = 1'b1;
        end else begin
            count_en_s = 1'b0;
        end
        // Word end always lands on the top bit, so the finished word is the
        // fresh bit on top of the bits already collected.
        word_s = {bit_val_s, shift_r[BITS-2:0]};
    end

    fsk_edge_counter #(
        .SAMPLES (SAMPLES),
        .HI_MIN  (HI_MIN),
        .LO_MAX  (LO_MAX)
    ) u_edge_counter (
        .clk      (clk),
        .reset    (reset),
        .fsk_in   (fsk_in),
        .restart  (align),
        .count_en (count_en_s),
        .win_end  (win_end_s),
        .bit_val  (bit_val_s),
        .bit_amb  (bit_amb_s)
    );

    // Frame FSM: align restarts the frame, window ends fill the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            bit_idx_r    <= '0;
            shift_r      <= '0;
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            bit_err_r    <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            bit_err_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (align) begin
                        state_r   <= RUN;
                        locked_r  <= 1'b1;
                        bit_idx_r <= '0;
                        shift_r   <= '0;
                    end else begin
                        locked_r  <= 1'b0;
                    end
                end
                RUN: begin
                    locked_r <= 1'b1;
                    if (align) begin
                        bit_idx_r <= '0;
                        shift_r   <= '0;
                    end else if (win_end_s) begin
                        bit_err_r          <= bit_amb_s;
                        shift_r[bit_idx_r] <= bit_val_s;
                        if (bit_idx_r == LAST_IDX_C) begin
                            data_out_r   <= word_s;
                            data_valid_r <= 1'b1;
                            bit_idx_r    <= '0;
                        end else begin
                            bit_idx_r    <= bit_idx_r + IW'(1);
                        end
                    end else begin
                        bit_idx_r <= bit_idx_r;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign bit_err    = bit_err_r;
    assign locked     = locked_r;

endmodule

// File: tb/tb_fsk_demod.sv
// Randomized self-checking bench for fsk_demod against a window-level model.
module tb_fsk_demod;
    import fsk_pkg::*;

    localparam int BITS    = FSK_BITS;
    localparam int SAMPLES = FSK_SAMPLES;
    localparam int HI      = FSK_HI_MIN;
    localparam int LO      = FSK_LO_MAX;
    localparam int WORD    = BITS * SAMPLES;
    localparam int MAXC    = 20000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            fsk_in = 1'b0;
    logic            align = 1'b0;
    logic [BITS-1:0] data_out;
    logic            data_valid;
    logic            bit_err;
    logic            locked;

    always #5 clk = ~clk;

    fsk_demod dut (
        .clk        (clk),
        .reset      (reset),
        .fsk_in     (fsk_in),
        .align      (align),
        .data_out   (data_out),
        .data_valid (data_valid),
        .bit_err    (bit_err),
        .locked     (locked)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: line history as transitions per clock edge, frame anchor = last align edge.
    int              k = 0;
    logic            ehist [0:MAXC-1];
    logic            last_f = 1'b0;
    bit              anchored = 1'b0;
    int              anchor = 0;
    logic [BITS-1:0] m_word = '0;
    logic [BITS-1:0] m_data = '0;
    logic            m_valid = 1'b0;
    logic            m_err = 1'b0;
    logic            m_locked = 1'b0;
    logic            mod_lvl = 1'b0;
    int              vq [$];
    int              err_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, got, exp);
    endtask

    task automatic model_edge(input logic r, input logic a, input logic f);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            last_f = 1'b0; anchored = 1'b0; m_word = '0; m_data = '0; m_locked = 1'b0;
            ehist[k] = 1'b0;
        end else begin
            ehist[k] = (f != last_f);
            last_f   = f;
            if (a) begin
                anchored = 1'b1; anchor = k; m_locked = 1'b1; m_word = '0;
            end else if (anchored && (k > anchor) && (((k - anchor) % SAMPLES) == 0)) begin
                int cnt;
                int idx;
                cnt = 0;
                for (int j = k - SAMPLES + 1; j <= k; j++) cnt += int'(ehist[j]);
                idx = ((k - anchor) / SAMPLES - 1) % BITS;
                m_word[idx] = (cnt >= HI);
                m_err       = (cnt > LO) && (cnt < HI);
                if (idx == BITS - 1) begin
                    m_data  = m_word;
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs after the edge.
    task automatic cyc(input logic r, input logic a, input logic f);
        int ek;
        if (k >= MAXC - 1) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", k, MAXC);
            $fatal(1);
        end
        reset = r; align = a; fsk_in = f;
        @(posedge clk);
        model_edge(r, a, f);
        ek = k;
        k++;
        #1;
        check_eq("data_valid", 32'(data_valid), 32'(m_valid));
        check_eq("bit_err",    32'(bit_err),    32'(m_err));
        check_eq("locked",     32'(locked),     32'(m_locked));
        check_eq("data_out",   32'(data_out),   32'(m_data));
        if (data_valid) vq.push_back(ek);
        if (bit_err) err_seen++;
    endtask

    // Ideal modulator: bit 1 toggles every clock, bit 0 every second clock.
    task automatic send_word(input logic [BITS-1:0] w);
        for (int i = 0; i < BITS; i++) begin
            for (int j = 0; j < SAMPLES; j++) begin
                if (w[i] || ((j % 2) == 0)) mod_lvl = ~mod_lvl;
                cyc(1'b0, 1'b0, mod_lvl);
            end
        end
    endtask

    // Arbitrary edge count per window: toggle on the first cnts[i] samples.
    task automatic send_counts(input int cnts [BITS]);
        for (int i = 0; i < BITS; i++) begin
            for (int j = 0; j < SAMPLES; j++) begin
                if (j < cnts[i]) mod_lvl = ~mod_lvl;
                cyc(1'b0, 1'b0, mod_lvl);
            end
        end
    endtask

    initial begin
        int cnts [BITS];
        int ka;
        logic [BITS-1:0] w;

        // Reset state.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
        check_eq("reset_locked", 32'(locked), 32'd0);

        // Idle: line activity without align.
        for (int i = 0; i < 500; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        check_eq("idle_valid_cnt", 32'(vq.size()), 32'd0);

        // Ideal A5C followed by a continuous FFF, 000, 5A3 stream.
        cyc(1'b0, 1'b1, mod_lvl);
        ka = k - 1;
        send_word(12'hA5C);
        check_eq("a5c_data", 32'(data_out), 32'h0A5C);
        check_eq("a5c_latency", 32'(vq[0] - ka), 32'(WORD));
        send_word(12'hFFF);
        check_eq("fff_data", 32'(data_out), 32'h0FFF);
        send_word(12'h000);
        check_eq("000_data", 32'(data_out), 32'h0000);
        send_word(12'h5A3);
        check_eq("5a3_data", 32'(data_out), 32'h05A3);
        check_eq("stream_valid_cnt", 32'(vq.size()), 32'd4);
        for (int i = 1; i < 4; i++) check_eq("stream_spacing", 32'(vq[i] - vq[i-1]), 32'(WORD));
        check_eq("stream_err_cnt", 32'(err_seen), 32'd0);

        // Threshold boundaries: 11 edges ambiguous, 12 -> 1, 10 -> 0.
        for (int i = 0; i < BITS; i++) cnts[i] = ((i % 2) == 0) ? 16 : 8;
        cnts[3] = 11; cnts[5] = 12; cnts[7] = 10;
        err_seen = 0;
        send_counts(cnts);
        check_eq("thresh_data", 32'(data_out), 32'h0575);
        check_eq("thresh_err_cnt", 32'(err_seen), 32'd1);

        // Reset mid-frame, then no output until aligned again.
        vq.delete();
        cyc(1'b0, 1'b1, mod_lvl);
        for (int i = 0; i < 100; i++) begin
            mod_lvl = ~mod_lvl;
            cyc(1'b0, 1'b0, mod_lvl);
        end
        cyc(1'b1, 1'b0, mod_lvl);
        check_eq("midreset_locked", 32'(locked), 32'd0);
        check_eq("midreset_data", 32'(data_out), 32'd0);
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        check_eq("midreset_valid_cnt", 32'(vq.size()), 32'd0);

        // Re-align 50 clocks into a word: partial word discarded.
        cyc(1'b0, 1'b1, mod_lvl);
        for (int i = 0; i < 50; i++) begin
            mod_lvl = ~mod_lvl;
            cyc(1'b0, 1'b0, mod_lvl);
        end
        cyc(1'b0, 1'b1, mod_lvl);
        ka = k - 1;
        check_eq("realign_valid_cnt", 32'(vq.size()), 32'd0);
        w = 12'($urandom);
        send_word(w);
        check_eq("realign_valid_seen", 32'(vq.size()), 32'd1);
        if (vq.size() > 0) check_eq("realign_latency", 32'(vq[0] - ka), 32'(WORD));
        check_eq("realign_data", 32'(data_out), 32'(w));

        // Random edge counts across the whole range, continuous words.
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < BITS; i++) cnts[i] = $urandom_range(0, SAMPLES);
            send_counts(cnts);
        end

        // Stuck line: all-zero word, no errors.
        err_seen = 0;
        for (int i = 0; i < WORD; i++) cyc(1'b0, 1'b0, mod_lvl);
        check_eq("stuck_data", 32'(data_out), 32'd0);
        check_eq("stuck_err_cnt", 32'(err_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
